// File: rtl/riscv_defines.sv
// Shared LSU encodings, FSM states and byte-enable/misalignment helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package riscv_defines;

    localparam logic [1:0] LSU_WORD = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } lsu_state_e;

    // Reserved type 2'b11 falls into the word case.
    function automatic logic [3:0] lsu_be(input logic [1:0] dtype, input logic [1:0] lsb);
        case (dtype)
            LSU_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
            LSU_BYTE: return 4'b0001 << lsb;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] dtype, input logic [1:0] lsb);
        case (dtype)
            LSU_HALF: return lsb[0];
            LSU_BYTE: return 1'b0;
            default:  return (lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_rdata_align.sv
// Extracts the addressed byte/half/word of a load response and extends it.
// Latency: purely combinational.
// Backpressure: none.
module riscv_lsu_rdata_align
    import riscv_defines::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  dtype_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  lsb_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lsb_i, 3'b000} +: 8];
        half_sel = rdata_i[{lsb_i[1], 4'b0000} +: 16];
        case (dtype_i)
            LSU_BYTE: rdata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            LSU_HALF: rdata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            default:  rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_dift_lsu.sv
// Load-store unit with one outstanding req/gnt/rvalid access; DIFT word tags under DIFT_LSU_TAG_EN.
// Latency: request issued combinationally from EX; load data returned in the rvalid cycle.
// Backpressure: lsu_ready_ex_o low while waiting for grant or response; new request accepted on rvalid.
module riscv_dift_lsu
    import riscv_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_ex_i,
    input  logic                  data_we_ex_i,
    input  logic [1:0]            data_type_ex_i,
    input  logic                  data_sign_ext_ex_i,
    input  logic [31:0]           operand_a_ex_i,
    input  logic [31:0]           operand_b_ex_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_ex_i,
    output logic                  lsu_ready_ex_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_rvalid_o,
    output logic                  data_misaligned_o,
    output logic                  busy_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
`ifdef DIFT_LSU_TAG_EN
    input  logic                  data_wdata_tag_i,
    input  logic                  data_we_tag_i,
    output logic                  data_wdata_tag_o,
    output logic                  data_we_tag_o,
    input  logic                  data_rdata_tag_i,
    output logic                  lsu_rdata_tag_o,
`endif
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  lsb_q, lsb_d;
    logic        we_q, we_d;

    logic [31:0] addr;
    logic        misaligned;
    logic        accept_window;

    always_comb begin
        addr       = operand_a_ex_i + operand_b_ex_i;
        misaligned = data_req_ex_i & lsu_misaligned(data_type_ex_i, addr[1:0]);

        state_d        = state_q;
        type_d         = type_q;
        sign_ext_d     = sign_ext_q;
        lsb_d          = lsb_q;
        we_d           = we_q;
        data_req_o     = 1'b0;
        lsu_ready_ex_o = 1'b1;
        accept_window  = 1'b0;

        case (state_q)
            IDLE:        accept_window = 1'b1;
            WAIT_GNT: begin
                data_req_o     = 1'b1;
                lsu_ready_ex_o = 1'b0;
            end
            WAIT_RVALID: begin
                lsu_ready_ex_o = data_rvalid_i;
                accept_window  = data_rvalid_i;
                if (data_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // IDLE and the rvalid cycle share the same issue path, giving back-to-back accesses.
        if (accept_window) data_req_o = data_req_ex_i & ~misaligned;

        if (data_req_o) begin
            if (data_gnt_i) begin
                state_d        = WAIT_RVALID;
                type_d         = data_type_ex_i;
                sign_ext_d     = data_sign_ext_ex_i;
                lsb_d          = addr[1:0];
                we_d           = data_we_ex_i;
                lsu_ready_ex_o = 1'b1;
            end else begin
                state_d        = WAIT_GNT;
                lsu_ready_ex_o = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            type_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            lsb_q      <= 2'b00;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            sign_ext_q <= sign_ext_d;
            lsb_q      <= lsb_d;
            we_q       <= we_d;
        end
    end

    assign data_misaligned_o = misaligned & accept_window;
    assign busy_o            = (state_q != IDLE);
    assign data_addr_o       = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign data_we_o         = data_we_ex_i;
    assign data_be_o         = lsu_be(data_type_ex_i, addr[1:0]);
    assign data_wdata_o      = data_wdata_ex_i << {addr[1:0], 3'b000};
    assign lsu_rvalid_o      = data_rvalid_i & (state_q == WAIT_RVALID) & ~we_q;

    riscv_lsu_rdata_align u_rdata_align (
        .rdata_i    (data_rdata_i),
        .dtype_i    (type_q),
        .sign_ext_i (sign_ext_q),
        .lsb_i      (lsb_q),
        .rdata_o    (lsu_rdata_o)
    );

`ifdef DIFT_LSU_TAG_EN
    // One tag per word: any store with the tag write enabled rewrites the word's tag.
    assign data_wdata_tag_o = data_wdata_tag_i;
    assign data_we_tag_o    = data_req_o & data_we_o & data_we_tag_i;
    assign lsu_rdata_tag_o  = lsu_rvalid_o & data_rdata_tag_i;
`endif

endmodule
